// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        BOOT_HDR_HI,
        BOOT_HDR_LO,
        BOOT_LOAD,
        BOOT_DONE,
        BOOT_ERR
    } t_boot_state;

    localparam int unsigned BOOT_HDR_BYTES = 2;
    localparam int unsigned BOOT_BYTE_W    = 8;
    localparam int unsigned BOOT_WORD_W    = 32;
    localparam int unsigned BOOT_CNT_HDR_W = 16;

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// Packs accepted bytes big-endian into 32-bit words; flags the word combinationally
// on the cycle its fourth byte is accepted so the top can register it once.
module imem_boot_loader_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   byte_valid_i,
    input  logic [BOOT_BYTE_W-1:0] byte_data_i,
    output logic                   word_valid_c,
    output logic [BOOT_WORD_W-1:0] word_c
);

    localparam int unsigned LEAD_W = BOOT_WORD_W - BOOT_BYTE_W;

    logic [1:0]        cnt_q, cnt_d;
    // Only the three leading bytes need storage; the last byte completes the word.
    logic [LEAD_W-1:0] shift_q, shift_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (byte_valid_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[LEAD_W-BOOT_BYTE_W-1:0], byte_data_i};
        end
    end

    assign word_valid_c = byte_valid_i && (cnt_q == 2'd3);
    assign word_c       = {shift_q, byte_data_i};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a word-count header, streams big-endian words into the
// instruction memory write port, and holds the core in reset until the load completes.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH_WORDS = 256,
    parameter int unsigned IMEM_ADDR_W      = $clog2(IMEM_DEPTH_WORDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   core_rst,
    output logic                   load_done,
    output logic                   load_err
);

    localparam int unsigned CNT_W = IMEM_ADDR_W + 1;
    localparam logic [BOOT_CNT_HDR_W:0] DEPTH_L = (BOOT_CNT_HDR_W+1)'(IMEM_DEPTH_WORDS);

    t_boot_state                state_q, state_d;
    logic [BOOT_BYTE_W-1:0]     hdr_hi_q, hdr_hi_d;
    logic [BOOT_CNT_HDR_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]           word_cnt_q, word_cnt_d;
    logic                       we_q, we_d;
    logic [IMEM_ADDR_W-1:0]     addr_q, addr_d;
    logic [BOOT_WORD_W-1:0]     wdata_q, wdata_d;
    logic                       core_rst_q, core_rst_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic                       xfer;
    logic [BOOT_CNT_HDR_W-1:0]  hdr_n;
    logic                       word_valid_c;
    logic [BOOT_WORD_W-1:0]     word_c;

    assign in_ready = !rst && (state_q inside {BOOT_HDR_HI, BOOT_HDR_LO, BOOT_LOAD});
    assign xfer     = in_valid && in_ready;
    assign hdr_n    = {hdr_hi_q, in_data};

    imem_boot_loader_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (xfer && (state_q == BOOT_LOAD)),
        .byte_data_i  (in_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT_HDR_HI;
            hdr_hi_q   <= '0;
            count_q    <= '0;
            word_cnt_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_hi_q   <= hdr_hi_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hdr_hi_d   = hdr_hi_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        err_d      = err_q;

        unique case (state_q)
            BOOT_HDR_HI: begin
                if (xfer) begin
                    hdr_hi_d = in_data;
                    state_d  = BOOT_HDR_LO;
                end
            end
            BOOT_HDR_LO: begin
                if (xfer) begin
                    count_d = hdr_n;
                    if (hdr_n == '0) begin
                        state_d    = BOOT_DONE;
                        core_rst_d = 1'b0;
                        done_d     = 1'b1;
                    end else if ({1'b0, hdr_n} > DEPTH_L) begin
                        state_d = BOOT_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = BOOT_LOAD;
                    end
                end
            end
            BOOT_LOAD: begin
                // The final write and the core's reset release share one edge.
                if (word_valid_c) begin
                    we_d       = 1'b1;
                    addr_d     = word_cnt_q[IMEM_ADDR_W-1:0];
                    wdata_d    = word_c;
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (BOOT_CNT_HDR_W'(word_cnt_q) + BOOT_CNT_HDR_W'(1) == count_q) begin
                        state_d    = BOOT_DONE;
                        core_rst_d = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            BOOT_DONE, BOOT_ERR: begin
            end
            default: state_d = BOOT_HDR_HI;
        endcase
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = rst || core_rst_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule
